sipo_frame_ctrl: RTL and testbench



---
 rtl/sipo_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: start-triggered WIDTH-bit capture with a
// valid/ready parallel output and sticky overrun. Optional parity: SIPO_FRAME_PARITY_EN.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             se_in_i,
  input  logic             out_ready_i,
  input  logic             clr_ovr_i,
  output logic [WIDTH-1:0] pa_out_o,
  output logic             pa_valid_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  typedef enum logic [1:0] {StIdle, StShift, StLoad, StPar} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pa_out_q, pa_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pa_valid_q, pa_valid_d;
  logic             overrun_q, overrun_d;
  logic             load_ok;
  logic             ovr_set;
`ifdef SIPO_FRAME_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    pa_out_d   = pa_out_q;
    pa_valid_d = pa_valid_q;
    load_ok    = 1'b0;
    ovr_set    = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif

    // Consumer handshake; a LOAD on the same edge overrides it below.
    if (pa_valid_q && out_ready_i) begin
      pa_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          shreg_d = {se_in_i, shreg_q[WIDTH-1:1]};
          cnt_d   = CNT_W'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = {se_in_i, shreg_q[WIDTH-1:1]};
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
`ifdef SIPO_FRAME_PARITY_EN
          state_d = StPar;
`else
          state_d = StLoad;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPar: begin
`ifdef SIPO_FRAME_PARITY_EN
        par_bit_d = se_in_i;
`endif
        state_d = StLoad;
      end
      StLoad: begin
        load_ok = !pa_valid_q || out_ready_i;
        ovr_set = !load_ok;
        if (load_ok) begin
          pa_out_d   = shreg_q;
          pa_valid_d = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
          parity_err_d = (^shreg_q) ^ par_bit_q;
`endif
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Setting the flag takes priority over a simultaneous clear.
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (clr_ovr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      pa_out_q   <= '0;
      pa_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      pa_out_q   <= pa_out_d;
      pa_valid_q <= pa_valid_d;
      overrun_q  <= overrun_d;
`ifdef SIPO_FRAME_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign pa_out_o   = pa_out_q;
  assign pa_valid_o = pa_valid_q;
  assign busy_o     = (state_q != StIdle);
  assign overrun_o  = overrun_q;
`ifdef SIPO_FRAME_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed frames plus random traffic, compared each cycle
// against a frame-level model built from a queue of received bits.
module tb_sipo_frame_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 4;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, se_in = 1'b0, out_ready = 1'b0, clr_ovr = 1'b0;
  logic [W-1:0] pa_out;
  logic         pa_valid, busy, overrun, parity_err;

  sipo_frame_ctrl #(
    .WIDTH(W),
    .CNT_W(CW)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .se_in_i     (se_in),
    .out_ready_i (out_ready),
    .clr_ovr_i   (clr_ovr),
    .pa_out_o    (pa_out),
    .pa_valid_o  (pa_valid),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .parity_err_o(parity_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned busy_cnt = 0;

  // Reference model: a frame is "active" from its start edge until its load edge.
  bit           m_active;
  bit           m_bits[$];
  logic [W-1:0] m_pa_out;
  bit           m_valid, m_ovr, m_perr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_bits.delete();
    m_pa_out = '0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_perr   = 1'b0;
  endtask

  task automatic model_edge();
    bit           do_load;
    bit           accept;
    bit           set_ovr;
    logic [W-1:0] word;
    do_load = m_active && (m_bits.size() == NB);
    set_ovr = 1'b0;
    if (do_load) begin
      word = '0;
      for (int i = 0; i < W; i++) word[i] = m_bits[i];
      accept = !m_valid || out_ready;
      if (accept) begin
        m_pa_out = word;
        m_valid  = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
        m_perr = (^word) ^ m_bits[W];
`endif
      end else begin
        set_ovr = 1'b1;
      end
      m_active = 1'b0;
      m_bits.delete();
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_active) begin
        m_bits.push_back(se_in);
      end else if (start) begin
        m_active = 1'b1;
        m_bits.push_back(se_in);
      end
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (clr_ovr) m_ovr = 1'b0;
  endtask

  task automatic check_all();
    check_eq("pa_out", 32'(pa_out), 32'(m_pa_out));
    check_eq("pa_valid", 32'(pa_valid), 32'(m_valid));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("parity_err", 32'(parity_err), 32'(m_perr));
  endtask

  task automatic cycle(input bit s, input bit d, input bit r, input bit c);
    start     = s;
    se_in     = d;
    out_ready = r;
    clr_ovr   = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (busy) busy_cnt++;
    check_all();
  endtask

  // Sends one frame (data LSB first, then parity if enabled) followed by the load cycle.
  task automatic frame(input logic [W-1:0] data, input bit par, input bit rdy, input bit rdy_ld);
    cycle(1'b1, data[0], rdy, 1'b0);
    for (int i = 1; i < W; i++) cycle(1'b0, data[i], rdy, 1'b0);
    if (NB > W) cycle(1'b0, par, rdy, 1'b0);
    cycle(1'b0, 1'b0, rdy_ld, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_pa_out", 32'(pa_out), 32'h0);
    check_eq("reset_pa_valid", 32'(pa_valid), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);
    check_eq("reset_overrun", 32'(overrun), 32'h0);
    check_eq("reset_parity_err", 32'(parity_err), 32'h0);
    rst = 1'b1;

    // Basic frame and busy duration.
    busy_cnt = 0;
    frame(4'b0101, 1'b0, 1'b1, 1'b1);
    check_eq("t1_word", 32'(pa_out), 32'h5);
    check_eq("t1_valid", 32'(pa_valid), 32'h1);
    check_eq("t1_busy_cycles", busy_cnt, NB);

    // Stall: second frame is dropped and flags overrun.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    frame(4'b0011, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    frame(4'b0001, 1'b1, 1'b0, 1'b0);
    check_eq("t2_word_kept", 32'(pa_out), 32'h3);
    check_eq("t2_overrun", 32'(overrun), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t2_overrun_clr", 32'(overrun), 32'h0);

    // Load and consume on the same edge: load wins.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    frame(4'b1111, 1'b0, 1'b0, 1'b0);
    frame(4'b0110, 1'b0, 1'b0, 1'b1);
    check_eq("t3_word", 32'(pa_out), 32'h6);
    check_eq("t3_valid", 32'(pa_valid), 32'h1);
    check_eq("t3_overrun", 32'(overrun), 32'h0);

    // Asynchronous reset mid-frame.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("t4_async_pa_out", 32'(pa_out), 32'h0);
    check_eq("t4_async_valid", 32'(pa_valid), 32'h0);
    check_eq("t4_async_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    frame(4'b0110, 1'b0, 1'b1, 1'b1);
    check_eq("t4_word", 32'(pa_out), 32'h6);

    // start held high continuously.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("t5_word", 32'(pa_out), 32'hF);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_FRAME_PARITY_EN
    frame(4'b0101, 1'b0, 1'b1, 1'b1);
    check_eq("t6_par_ok", 32'(parity_err), 32'h0);
    frame(4'b0101, 1'b1, 1'b1, 1'b1);
    check_eq("t6_par_err", 32'(parity_err), 32'h1);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) == 0, 1'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
